// File: rtl/tone_nav_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tone_nav_sequencer
// Brief   : Arms tone detection, accepts one direction code, drives motors
//           for a code-specific time, cools down, then re-arms.
// Revision: 1.0
// ============================================================================
module tone_nav_sequencer #(
    parameter int unsigned STRAIGHT_CYC   = 50_000_000,
    parameter int unsigned TURN_CYC       = 25_000_000,
    parameter int unsigned BACK_CYC       = 50_000_000,
    parameter int unsigned COOLDOWN_CYC   = 5_000_000,
    parameter int unsigned LISTEN_TIMEOUT = 500_000_000,
    parameter int unsigned CNT_W          = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       abort,
    input  logic [2:0] toneDir,
    output logic       enableToneDetection,
    output logic       motorL_en,
    output logic       motorR_en,
    output logic       motorL_dir,
    output logic       motorR_dir,
    output logic       busy,
    output logic [2:0] lastDir,
    output logic       moveDone,
    output logic       timeout
);

    generate
        if ((64'(STRAIGHT_CYC)   >= (64'd1 << CNT_W)) ||
            (64'(TURN_CYC)       >= (64'd1 << CNT_W)) ||
            (64'(BACK_CYC)       >= (64'd1 << CNT_W)) ||
            (64'(COOLDOWN_CYC)   >= (64'd1 << CNT_W)) ||
            (64'(LISTEN_TIMEOUT) >= (64'd1 << CNT_W))) begin : g_param_check
            $error("tone_nav_sequencer: a cycle parameter does not fit in CNT_W bits");
        end
    endgenerate

    // Zero-length durations are clamped to one cycle so every phase is observable.
    localparam logic [CNT_W-1:0] c_straight_ld = CNT_W'((STRAIGHT_CYC   > 0) ? STRAIGHT_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] c_turn_ld     = CNT_W'((TURN_CYC       > 0) ? TURN_CYC       - 1 : 0);
    localparam logic [CNT_W-1:0] c_back_ld     = CNT_W'((BACK_CYC       > 0) ? BACK_CYC       - 1 : 0);
    localparam logic [CNT_W-1:0] c_cool_ld     = CNT_W'((COOLDOWN_CYC   > 0) ? COOLDOWN_CYC   - 1 : 0);
    localparam logic [CNT_W-1:0] c_listen_last = CNT_W'((LISTEN_TIMEOUT > 0) ? LISTEN_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LISTEN   = 2'd1,
        S_MOVE     = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_to_latch;
    logic             w_code_valid;

    assign w_code_valid = (toneDir >= 3'd1) && (toneDir <= 3'd4);

    function automatic logic [CNT_W-1:0] f_dur_ld(input logic [2:0] code);
        case (code)
            3'd1:       return c_straight_ld;
            3'd2, 3'd3: return c_turn_ld;
            3'd4:       return c_back_ld;
            default:    return '0;
        endcase
    endfunction

    // {left_dir, right_dir}; 1 = forward
    function automatic logic [1:0] f_dirs(input logic [2:0] code);
        case (code)
            3'd1:    return 2'b11;
            3'd2:    return 2'b01;
            3'd3:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            r_to_latch          <= 1'b0;
            enableToneDetection <= 1'b0;
            motorL_en           <= 1'b0;
            motorR_en           <= 1'b0;
            motorL_dir          <= 1'b0;
            motorR_dir          <= 1'b0;
            busy                <= 1'b0;
            lastDir             <= 3'd0;
            moveDone            <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            moveDone <= 1'b0;
            timeout  <= 1'b0;
            if (abort) begin
                r_state             <= S_IDLE;
                r_cnt               <= '0;
                enableToneDetection <= 1'b0;
                motorL_en           <= 1'b0;
                motorR_en           <= 1'b0;
                motorL_dir          <= 1'b0;
                motorR_dir          <= 1'b0;
                busy                <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!run) begin
                            r_to_latch <= 1'b0;
                        end
                        if (run && !r_to_latch) begin
                            r_state             <= S_LISTEN;
                            r_cnt               <= '0;
                            enableToneDetection <= 1'b1;
                            busy                <= 1'b1;
                        end
                    end
                    S_LISTEN: begin
                        if (!run) begin
                            r_state             <= S_IDLE;
                            enableToneDetection <= 1'b0;
                            busy                <= 1'b0;
                        end else if (w_code_valid) begin
                            r_state                  <= S_MOVE;
                            r_cnt                    <= f_dur_ld(toneDir);
                            lastDir                  <= toneDir;
                            enableToneDetection      <= 1'b0;
                            motorL_en                <= 1'b1;
                            motorR_en                <= 1'b1;
                            {motorL_dir, motorR_dir} <= f_dirs(toneDir);
                        end else if (r_cnt == c_listen_last) begin
                            r_state             <= S_IDLE;
                            r_to_latch          <= 1'b1;
                            timeout             <= 1'b1;
                            enableToneDetection <= 1'b0;
                            busy                <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                    S_MOVE: begin
                        if (r_cnt == '0) begin
                            r_state    <= S_COOLDOWN;
                            r_cnt      <= c_cool_ld;
                            moveDone   <= 1'b1;
                            motorL_en  <= 1'b0;
                            motorR_en  <= 1'b0;
                            motorL_dir <= 1'b0;
                            motorR_dir <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - c_one;
                        end
                    end
                    S_COOLDOWN: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_one;
                        end else if (run) begin
                            r_state             <= S_LISTEN;
                            r_cnt               <= '0;
                            enableToneDetection <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_nav_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_tone_nav_sequencer
// Brief   : Scoreboard bench: stimulus queues expected move/timeout events,
//           a negedge monitor pops them when moveDone/timeout pulse.
// Revision: 1.0
// ============================================================================
module tb_tone_nav_sequencer;

    localparam int unsigned c_STRAIGHT = 10;
    localparam int unsigned c_TURN     = 5;
    localparam int unsigned c_BACK     = 8;
    localparam int unsigned c_COOL     = 3;
    localparam int unsigned c_LTO      = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] toneDir = 3'd0;
    logic       enableToneDetection, motorL_en, motorR_en, motorL_dir, motorR_dir;
    logic       busy, moveDone, timeout;
    logic [2:0] lastDir;

    tone_nav_sequencer #(
        .STRAIGHT_CYC  (c_STRAIGHT),
        .TURN_CYC      (c_TURN),
        .BACK_CYC      (c_BACK),
        .COOLDOWN_CYC  (c_COOL),
        .LISTEN_TIMEOUT(c_LTO),
        .CNT_W         (29)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .run                (run),
        .abort              (abort),
        .toneDir            (toneDir),
        .enableToneDetection(enableToneDetection),
        .motorL_en          (motorL_en),
        .motorR_en          (motorR_en),
        .motorL_dir         (motorL_dir),
        .motorR_dir         (motorR_dir),
        .busy               (busy),
        .lastDir            (lastDir),
        .moveDone           (moveDone),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_to;
        logic [2:0] code;
        int         dur;
        logic [3:0] pat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [2:0] m_last = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: duration and {L_en,R_en,L_dir,R_dir} per direction code
    function automatic int exp_dur(input logic [2:0] c);
        case (c)
            3'd1:       return c_STRAIGHT;
            3'd2, 3'd3: return c_TURN;
            3'd4:       return c_BACK;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_pat(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b1111;
            3'd2:    return 4'b1101;
            3'd3:    return 4'b1110;
            3'd4:    return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] rand_invalid();
        int v;
        v = $urandom_range(0, 3);
        return (v == 0) ? 3'd0 : 3'(v + 4);
    endfunction

    // ---------------- monitor ----------------
    int         cur_len = 0, done_len = 0, l_len = 0, l_done = 0;
    logic [3:0] cur_pat = 4'd0, done_pat = 4'd0;
    bit         glitch = 1'b0, done_glitch = 1'b0;

    always @(negedge clk) begin
        logic [3:0] pat;
        exp_t       e;
        pat = {motorL_en, motorR_en, motorL_dir, motorR_dir};
        if (motorL_en === 1'b1 || motorR_en === 1'b1) begin
            if (cur_len == 0) begin
                cur_pat = pat;
                glitch  = 1'b0;
            end else if (pat !== cur_pat) begin
                glitch = 1'b1;
            end
            cur_len++;
        end else if (cur_len > 0) begin
            done_len    = cur_len;
            done_pat    = cur_pat;
            done_glitch = glitch;
            cur_len     = 0;
        end
        if (enableToneDetection === 1'b1) begin
            l_len++;
        end else if (l_len > 0) begin
            l_done = l_len;
            l_len  = 0;
        end
        chk("motor_listen_exclusive",
            32'(((motorL_en === 1'b1) || (motorR_en === 1'b1)) && (enableToneDetection === 1'b1)), 0);
        if (moveDone === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_moveDone", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("event_kind_move", 32'(e.is_to), 0);
                chk("move_len", done_len, e.dur);
                chk("move_pattern", 32'(done_pat), 32'(e.pat));
                chk("move_pattern_stable", 32'(done_glitch), 0);
                chk("lastDir_at_done", 32'(lastDir), 32'(e.code));
            end
        end
        if (timeout === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_timeout", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("event_kind_timeout", 32'(e.is_to), 1);
                chk("listen_len_at_timeout", l_done, c_LTO);
                chk("lastDir_at_timeout", 32'(lastDir), 32'(e.code));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input int budget, input string name);
        int n;
        n = 0;
        while (enableToneDetection !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (enableToneDetection !== 1'b1) chk(name, 0, 1);
    endtask

    task automatic issue(input logic [2:0] code, input int delay, input bit expect_done);
        wait_enable(40, "wait_listen");
        repeat (delay) begin
            toneDir = rand_invalid();
            tick();
        end
        toneDir = code;
        if (expect_done) sb.push_back('{1'b0, code, exp_dur(code), exp_pat(code)});
        m_last = code;
        tick();
        toneDir = 3'd0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (moveDone !== 1'b1 && n < 60) begin
            toneDir = 3'($urandom);
            tick();
            n++;
        end
        toneDir = 3'd0;
        if (moveDone !== 1'b1) chk("wait_moveDone", 0, 1);
    endtask

    task automatic check_relisten(input string name);
        int k;
        k = 0;
        while (enableToneDetection !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk(name, k, c_COOL);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enable"}, 32'(enableToneDetection), 0);
        chk({tag, "_motors"}, 32'({motorL_en, motorR_en, motorL_dir, motorR_dir}), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pulses"}, 32'({moveDone, timeout}), 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check_all_zero("reset");
        chk("reset_lastDir", 32'(lastDir), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy_run0", 32'(busy), 0);

        // Straight move
        run = 1'b1;
        issue(3'd1, 0, 1'b1);
        chk("straight_enable_drop", 32'(enableToneDetection), 0);
        chk("straight_motors_on", 32'({motorL_en, motorR_en, motorL_dir, motorR_dir}), 32'(4'b1111));
        wait_done();
        check_relisten("straight_cooldown_len");
        chk("straight_lastDir", 32'(lastDir), 1);

        // Left then right pivot
        issue(3'd2, 2, 1'b1);
        wait_done();
        chk("left_lastDir", 32'(lastDir), 2);
        check_relisten("left_cooldown_len");
        issue(3'd3, 1, 1'b1);
        wait_done();
        chk("right_lastDir", 32'(lastDir), 3);
        check_relisten("right_cooldown_len");

        // Listen timeout with hold then invalid code
        sb.push_back('{1'b1, m_last, 0, 4'd0});
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            toneDir = (n < 8) ? 3'd0 : 3'd6;
            tick();
            n++;
        end
        toneDir = 3'd0;
        if (timeout !== 1'b1) chk("wait_timeout", 0, 1);
        chk("timeout_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("timeout_no_reentry_enable", 32'(enableToneDetection), 0);
        chk("timeout_no_reentry_busy", 32'(busy), 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        wait_enable(4, "relisten_after_run_toggle");
        chk("relisten_busy", 32'(busy), 1);

        // Abort on cycle 4 of a back move
        issue(3'd4, $urandom_range(0, 6), 1'b0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        chk("abort_motors_off", 32'({motorL_en, motorR_en}), 0);
        chk("abort_enable", 32'(enableToneDetection), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_lastDir", 32'(lastDir), 4);
        abort = 1'b0;
        run = 1'b0;
        repeat (12) begin
            tick();
            chk("abort_no_moveDone", 32'(moveDone), 0);
        end

        // Run dropped mid straight
        run = 1'b1;
        issue(3'd1, $urandom_range(0, 6), 1'b1);
        repeat (3) tick();
        run = 1'b0;
        wait_done();
        chk("rundrop_cool_busy0", 32'(busy), 1);
        tick();
        chk("rundrop_cool_busy1", 32'(busy), 1);
        tick();
        chk("rundrop_cool_busy2", 32'(busy), 1);
        tick();
        chk("rundrop_idle_busy", 32'(busy), 0);
        repeat (4) begin
            tick();
            chk("rundrop_idle_enable", 32'(enableToneDetection), 0);
        end

        // Reset during cooldown
        run = 1'b1;
        issue(3'd3, $urandom_range(0, 6), 1'b1);
        wait_done();
        rst = 1'b1;
        tick();
        check_all_zero("rst_cooldown");
        chk("rst_cooldown_lastDir", 32'(lastDir), 0);
        rst = 1'b0;
        m_last = 3'd0;

        // Randomized moves
        for (int i = 0; i < 8; i++) begin
            logic [2:0] code;
            code = 3'($urandom_range(1, 4));
            issue(code, $urandom_range(0, 10), 1'b1);
            wait_done();
            check_relisten("rand_cooldown_len");
        end

        run = 1'b0;
        repeat (30) tick();
        chk("scoreboard_drained", sb.size(), 0);
        chk("final_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tone_nav_sequencer.md
Name: tone_nav_sequencer

Overview:
- Sequences the tone detector and the drive motors for one-command-at-a-time navigation.
- Arms tone detection, waits for a direction code, and disarms detection while the robot moves.
- Drives both motors for a direction-specific time, then waits through a cooldown and re-arms.
- Sits between the tone detection block (drives its enableToneDetection, consumes its toneDir) and the motor driver outputs.

Parameters:
- STRAIGHT_CYC, 50_000_000: cycles both motors run forward for TD_STRAIGHT.
- TURN_CYC, 25_000_000: cycles of the pivot for TD_LEFT or TD_RIGHT.
- BACK_CYC, 50_000_000: cycles both motors run reverse for TD_BACK.
- COOLDOWN_CYC, 5_000_000: cycles with motors off before re-listening.
- LISTEN_TIMEOUT, 500_000_000: maximum LISTEN cycles with no detection.
- CNT_W, 29: counter width; must hold the largest parameter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level request; 1 = keep listening and moving, 0 = stop after the current move.
- abort  in  1  immediate stop: motors off, go to IDLE.
- toneDir  in  3  direction code from tone detection. TD_HOLD=0, TD_STRAIGHT=1, TD_LEFT=2, TD_RIGHT=3, TD_BACK=4; codes 5-7 are invalid.
- enableToneDetection  out  1  arms the tone detector.
- motorL_en, motorR_en  out  1 each  motor enables.
- motorL_dir, motorR_dir  out  1 each  1 = forward, 0 = reverse.
- busy  out  1  high in any state other than IDLE.
- lastDir  out  3  last accepted direction code.
- moveDone  out  1  one-cycle pulse at the end of a move.
- timeout  out  1  one-cycle pulse when LISTEN times out.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, lastDir = TD_HOLD, state IDLE, counter 0, timeout latch 0.
- States: IDLE, LISTEN, MOVE, COOLDOWN.
- IDLE:
  - outputs low.
  - if run=1 and the timeout latch is 0, go to LISTEN next cycle; counter = 0.
  - run=0 clears the timeout latch.
- LISTEN:
  - enableToneDetection=1 in every LISTEN cycle; the counter increments each cycle.
  - toneDir in 1..4: latch lastDir, load counter with the duration for that code minus 1, go to MOVE.
  - enableToneDetection drops in the same registered update as entry to MOVE.
  - toneDir = 0 or 5..7: ignored.
  - counter reaches LISTEN_TIMEOUT-1 with no valid code: pulse timeout, set the timeout latch, go to IDLE.
  - a valid code on the timeout cycle wins: go to MOVE, no timeout pulse.
  - run=0 while in LISTEN: go to IDLE next cycle.
- MOVE:
  - motors are asserted for exactly the duration cycles for the latched code.
  - STRAIGHT: L and R en=1, dir=1.
  - BACK: L and R en=1, dir=0.
  - LEFT: L dir=0, R dir=1, both en.
  - RIGHT: L dir=1, R dir=0, both en.
  - counter decrements each cycle; at 0: motors off next cycle, pulse moveDone, load COOLDOWN_CYC-1, go to COOLDOWN.
  - toneDir is ignored throughout MOVE.
  - run changes during MOVE do not shorten the move.
- COOLDOWN:
  - motors off, enableToneDetection=0.
  - counter decrements; at 0: go to LISTEN (counter=0) if run=1, else IDLE.
  - COOLDOWN_CYC=0 is treated as 1.
- enableToneDetection is low outside LISTEN. This forces the detector back to TD_HOLD, so a stale code is never reaccepted on re-entry to LISTEN.
- abort has priority over everything in any state: next cycle all motor outputs 0, enableToneDetection 0, state IDLE.
  - abort gives no moveDone and no timeout pulse.
  - lastDir is retained.
- rst mid-move: same as abort, plus lastDir and the timeout latch are cleared.
- Counter width: CNT_W bits, no wrap. Parameter values must be below 2^CNT_W; this is checked at elaboration.

Test Plan:
- Use STRAIGHT_CYC=10, TURN_CYC=5, BACK_CYC=8, COOLDOWN_CYC=3, LISTEN_TIMEOUT=20 for all cases.
- run=1, toneDir=1 for 1 cycle in LISTEN:
  - enable drops.
  - motorL/R en=1, dir=1 for exactly 10 cycles.
  - moveDone pulses once; 3 cooldown cycles follow; enable=1 again; lastDir=1.
- toneDir=2, then after re-listen toneDir=3:
  - first move: L dir=0 / R dir=1 pivot for 5 cycles.
  - second move: L dir=1 / R dir=0 pivot for 5 cycles.
  - lastDir is 2, then 3.
- run=1, toneDir held 0 and then 6:
  - timeout pulses on LISTEN cycle 20; state IDLE; busy=0.
  - no re-entry while run=1; toggling run 0→1 re-enters LISTEN.
- abort asserted on cycle 4 of a BACK move:
  - motors 0 next cycle; IDLE; no moveDone; lastDir=4.
- run dropped mid-STRAIGHT:
  - move completes all 10 cycles; cooldown runs; then IDLE, enable stays 0.
- rst asserted during cooldown:
  - next cycle all outputs 0, lastDir=0, state IDLE.
